// File: rtl/openofdm_tx_sig_gen.sv
// TX PHY header generator: serialises L-SIG (and, with OPENOFDM_TX_HT_SIG_EN defined,
// HT-SIG1/HT-SIG2 with CRC-8) one bit per valid/ready handshake toward the encoder.
module openofdm_tx_sig_gen #(
  parameter int unsigned HT_LEN_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ht,
  input  logic [3:0]              legacy_rate,
  input  logic [11:0]             legacy_len,
  input  logic [6:0]              ht_mcs,
  input  logic                    ht_cbw,
  input  logic [HT_LEN_WIDTH-1:0] ht_len,
  input  logic                    ht_smoothing,
  input  logic                    ht_not_sounding,
  input  logic                    ht_aggr,
  input  logic [1:0]              ht_stbc,
  input  logic                    ht_fec,
  input  logic                    ht_sgi,
  input  logic [1:0]              ht_num_ext,
  output logic                    bit_out,
  output logic                    bit_out_valid,
  input  logic                    bit_out_ready,
  output logic                    bit_out_last,
  output logic [1:0]              sym_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CNT_W       = 5;
  localparam int unsigned LSIG_DATA_W = 17;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(23);
  localparam logic [CNT_W-1:0] PARITY_BIT = CNT_W'(17);
  localparam logic [3:0]       RATE_6M    = 4'b1011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSIG   = 2'd1,
    HTSIG1 = 2'd2,
    HTSIG2 = 2'd3
  } state_t;

  state_t                   state_q, state_n;
  logic [CNT_W-1:0]         cnt_q, cnt_n;
  logic                     parity_q, parity_n;
  logic [LSIG_DATA_W-1:0]   lsig_q, lsig_n;
  logic                     done_n;
  logic                     xfer;
  logic                     bit_n;
  logic [1:0]               sym_n;

`ifdef OPENOFDM_TX_HT_SIG_EN
  localparam int unsigned HT1_W      = HT_LEN_WIDTH + 8;
  localparam int unsigned HT2_DATA_W = 10;
  localparam logic [CNT_W-1:0] CRC_FIRST = CNT_W'(10);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(17);

  logic                  ht_q, ht_n;
  logic [HT1_W-1:0]      ht1_q, ht1_n;
  logic [HT2_DATA_W-1:0] ht2_q, ht2_n;
  logic [7:0]            crc_q, crc_n;

  // One serial step of x^8+x^2+x+1
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[7];
    return {crc[6:0], 1'b0} ^ {5'b0, fb, fb, fb};
  endfunction
`else
  logic unused_ht;
  assign unused_ht = ^{ht, ht_mcs, ht_cbw, ht_len, ht_smoothing, ht_not_sounding,
                       ht_aggr, ht_stbc, ht_fec, ht_sgi, ht_num_ext};
`endif

  // Next-state and next-output logic; outputs are derived from the next register values
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    parity_n = parity_q;
    lsig_n   = lsig_q;
    done_n   = 1'b0;
    bit_n    = 1'b0;
    sym_n    = 2'd0;
    xfer     = bit_out_valid & bit_out_ready;
`ifdef OPENOFDM_TX_HT_SIG_EN
    ht_n  = ht_q;
    ht1_n = ht1_q;
    ht2_n = ht2_q;
    crc_n = crc_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n  = LSIG;
          cnt_n    = '0;
          parity_n = 1'b0;
`ifdef OPENOFDM_TX_HT_SIG_EN
          ht_n   = ht;
          ht1_n  = {ht_len, ht_cbw, ht_mcs};
          ht2_n  = {ht_num_ext, ht_sgi, ht_fec, ht_stbc, ht_aggr, 1'b1,
                    ht_not_sounding, ht_smoothing};
          crc_n  = 8'hFF;
          lsig_n = {legacy_len, 1'b0, ht ? RATE_6M : legacy_rate};
`else
          lsig_n = {legacy_len, 1'b0, legacy_rate};
`endif
        end
      end
      default: begin
        if (xfer) begin
          if (state_q == LSIG && cnt_q < PARITY_BIT) parity_n = parity_q ^ bit_out;
`ifdef OPENOFDM_TX_HT_SIG_EN
          if (state_q == HTSIG1 || (state_q == HTSIG2 && cnt_q < CRC_FIRST))
            crc_n = crc_step(crc_q, bit_out);
`endif
          if (cnt_q == LAST_BIT) begin
            cnt_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
`ifdef OPENOFDM_TX_HT_SIG_EN
            if (state_q == LSIG && ht_q) begin
              state_n = HTSIG1;
              done_n  = 1'b0;
            end else if (state_q == HTSIG1) begin
              state_n = HTSIG2;
              done_n  = 1'b0;
            end
`endif
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase

    case (state_n)
      LSIG: begin
        if (cnt_n < PARITY_BIT)       bit_n = lsig_n[cnt_n];
        else if (cnt_n == PARITY_BIT) bit_n = parity_n;
      end
`ifdef OPENOFDM_TX_HT_SIG_EN
      HTSIG1: begin
        sym_n = 2'd1;
        bit_n = ht1_n[cnt_n];
      end
      HTSIG2: begin
        sym_n = 2'd2;
        if (cnt_n < CRC_FIRST)      bit_n = ht2_n[cnt_n[3:0]];
        else if (cnt_n <= CRC_LAST) bit_n = ~crc_n[3'(CRC_LAST - cnt_n)];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      parity_q      <= 1'b0;
      lsig_q        <= '0;
      bit_out       <= 1'b0;
      bit_out_valid <= 1'b0;
      bit_out_last  <= 1'b0;
      sym_idx       <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef OPENOFDM_TX_HT_SIG_EN
      ht_q  <= 1'b0;
      ht1_q <= '0;
      ht2_q <= '0;
      crc_q <= 8'hFF;
`endif
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      parity_q      <= parity_n;
      lsig_q        <= lsig_n;
      bit_out       <= bit_n;
      bit_out_valid <= (state_n != IDLE);
      bit_out_last  <= (state_n != IDLE) && (cnt_n == LAST_BIT);
      sym_idx       <= sym_n;
      busy          <= (state_n != IDLE);
      done          <= done_n;
`ifdef OPENOFDM_TX_HT_SIG_EN
      ht_q  <= ht_n;
      ht1_q <= ht1_n;
      ht2_q <= ht2_n;
      crc_q <= crc_n;
`endif
    end
  end

endmodule

// File: tb/tb_openofdm_tx_sig_gen.sv
// Directed scoreboard bench for openofdm_tx_sig_gen (legacy and OPENOFDM_TX_HT_SIG_EN builds).
module tb_openofdm_tx_sig_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ht;
  logic [3:0]  legacy_rate;
  logic [11:0] legacy_len;
  logic [6:0]  ht_mcs;
  logic        ht_cbw;
  logic [15:0] ht_len;
  logic        ht_smoothing, ht_not_sounding, ht_aggr, ht_fec, ht_sgi;
  logic [1:0]  ht_stbc, ht_num_ext;
  logic        bit_out, bit_out_valid, bit_out_ready, bit_out_last, busy, done;
  logic [1:0]  sym_idx;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [1:0] sym;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [23:0] lsig_seen;
  logic [23:0] ht2_seen;

  openofdm_tx_sig_gen #(.HT_LEN_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .ht(ht),
    .legacy_rate(legacy_rate), .legacy_len(legacy_len),
    .ht_mcs(ht_mcs), .ht_cbw(ht_cbw), .ht_len(ht_len),
    .ht_smoothing(ht_smoothing), .ht_not_sounding(ht_not_sounding),
    .ht_aggr(ht_aggr), .ht_stbc(ht_stbc), .ht_fec(ht_fec), .ht_sgi(ht_sgi),
    .ht_num_ext(ht_num_ext),
    .bit_out(bit_out), .bit_out_valid(bit_out_valid), .bit_out_ready(bit_out_ready),
    .bit_out_last(bit_out_last), .sym_idx(sym_idx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_bits(input logic [33:0] m);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int i = 0; i < 34; i++) begin
      fb = m[i] ^ c[7];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return ~c;
  endfunction

  function automatic void push_word(input logic [23:0] v, input logic [1:0] sym);
    for (int i = 0; i < 24; i++) q.push_back('{b: v[i], last: (i == 23), sym: sym});
  endfunction

  // Expected header bits derived from the current stimulus fields
  function automatic void push_expected();
    logic [23:0] v0, v1, v2;
    logic [7:0]  c;
    logic        use_ht;
`ifdef OPENOFDM_TX_HT_SIG_EN
    use_ht = ht;
`else
    use_ht = 1'b0;
`endif
    v0        = '0;
    v0[3:0]   = use_ht ? 4'b1011 : legacy_rate;
    v0[16:5]  = legacy_len;
    v0[17]    = ^v0[16:0];
    push_word(v0, 2'd0);
    if (use_ht) begin
      v1      = {ht_len, ht_cbw, ht_mcs};
      v2      = '0;
      v2[9:0] = {ht_num_ext, ht_sgi, ht_fec, ht_stbc, ht_aggr, 1'b1, ht_not_sounding, ht_smoothing};
      c       = crc_bits({v2[9:0], v1});
      for (int k = 0; k < 8; k++) v2[10+k] = c[7-k];
      push_word(v1, 2'd1);
      push_word(v2, 2'd2);
    end
  endfunction

  task automatic run_seq(input int mode, input int pulse_cyc, input int reset_cyc, input int exp_done);
    int         cyc, last_xfer, pos0, pos2;
    bit         fin, hold_v;
    logic [3:0] hold;
    exp_t       e;
    lsig_seen = '0;
    ht2_seen  = '0;
    pos0 = 0; pos2 = 0; last_xfer = 0; fin = 0; hold_v = 0; hold = '0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    cyc = 1;
    while (!fin && cyc < 300) begin
      start         = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) legacy_len = 12'h5A5;
      bit_out_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      reset         = (cyc == reset_cyc);
      @(negedge clock);
      if (cyc != reset_cyc) begin
        if (hold_v) check("hold_stable", 32'({bit_out, bit_out_last, sym_idx}), 32'(hold));
        if (done) begin
          check("done_cycle", 32'(cyc), 32'(exp_done));
          check("done_after_last", 32'(cyc), 32'(last_xfer + 1));
          check("done_valid_busy", 32'({bit_out_valid, busy}), 32'(0));
          check("queue_drained", 32'(q.size()), 32'(0));
          fin = 1;
        end else begin
          check("valid_busy_mid", 32'({bit_out_valid, busy}), 32'(3));
          if (bit_out_valid && bit_out_ready) begin
            check("queue_nonempty", 32'(q.size() != 0), 32'(1));
            if (q.size() != 0) begin
              e = q.pop_front();
              check("bit_last_sym", 32'({bit_out, bit_out_last, sym_idx}), 32'(e));
            end
            if (sym_idx == 2'd0 && pos0 < 24) begin lsig_seen[pos0] = bit_out; pos0++; end
            if (sym_idx == 2'd2 && pos2 < 24) begin ht2_seen[pos2] = bit_out; pos2++; end
            last_xfer = cyc;
          end
        end
        hold_v = bit_out_valid && !bit_out_ready;
        hold   = {bit_out, bit_out_last, sym_idx};
      end
      @(posedge clock);
      #1;
      if (cyc == reset_cyc) begin
        reset = 1'b0;
        check("midop_reset_outputs",
              32'({bit_out, bit_out_valid, bit_out_last, sym_idx, busy, done}), 32'(0));
        q.delete();
        bit_out_ready = 1'b1;
        return;
      end
      cyc++;
    end
    start         = 1'b0;
    bit_out_ready = 1'b1;
    check("no_timeout", 32'(fin), 32'(1));
    repeat (3) begin
      @(negedge clock);
      check("idle_after_done", 32'({done, bit_out_valid, busy}), 32'(0));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ht = 1'b0; bit_out_ready = 1'b1;
    legacy_rate = 4'b1011; legacy_len = 12'd100;
    ht_mcs = '0; ht_cbw = 0; ht_len = '0; ht_smoothing = 0; ht_not_sounding = 0;
    ht_aggr = 0; ht_stbc = '0; ht_fec = 0; ht_sgi = 0; ht_num_ext = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_bit_out", 32'(bit_out), 32'(0));
    check("rst_valid", 32'(bit_out_valid), 32'(0));
    check("rst_last", 32'(bit_out_last), 32'(0));
    check("rst_sym_idx", 32'(sym_idx), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    reset = 1'b0;

    // Legacy, ready held high
    push_expected();
    run_seq(0, -1, -1, 25);
    check("legacy_lsig_bits", 32'(lsig_seen), 32'h000C8B);

    // Backpressure: ready toggles, 24th transfer in cycle 48
    push_expected();
    run_seq(1, -1, -1, 49);
    check("bp_lsig_bits", 32'(lsig_seen), 32'h000C8B);

    // start while busy (bit 5 on the wire) is ignored
    legacy_len = 12'd100;
    push_expected();
    run_seq(0, 6, -1, 25);

    // Reset while bit 10 is on the wire, then a fresh sequence
    legacy_len  = 12'h2C7;
    legacy_rate = 4'b0101;
    push_expected();
    run_seq(0, -1, 11, 25);
    push_expected();
    run_seq(0, -1, -1, 25);

`ifdef OPENOFDM_TX_HT_SIG_EN
    // HT with zero fields: known CRC 0x3B
    ht = 1'b1; legacy_rate = 4'b0110; legacy_len = 12'd100;
    push_expected();
    run_seq(0, -1, -1, 73);
    check("ht2_fields_and_crc", 32'(ht2_seen[17:0]), 32'({8'b11011100, 10'b0000000100}));
    check("ht_lsig_rate_forced", 32'(lsig_seen[3:0]), 32'(4'b1011));

    // HT with populated fields under backpressure
    ht_mcs = 7'h25; ht_cbw = 1; ht_len = 16'hBEEF; ht_smoothing = 1; ht_not_sounding = 0;
    ht_aggr = 1; ht_stbc = 2'b10; ht_fec = 1; ht_sgi = 0; ht_num_ext = 2'b01;
    push_expected();
    run_seq(1, -1, -1, 145);
`else
    // ht requested without HT support: L-SIG only with unforced rate
    ht = 1'b1; legacy_rate = 4'b0110; legacy_len = 12'h3E7;
    ht_mcs = 7'h25; ht_len = 16'hBEEF;
    push_expected();
    run_seq(0, -1, -1, 25);
    check("noht_lsig_rate", 32'(lsig_seen[3:0]), 32'(4'b0110));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/openofdm_tx_sig_gen.md
# openofdm_tx_sig_gen

Transmit-side PHY header generator: the counterpart of the receiver's SIGNAL/HT-SIG decode path. On a start pulse it latches the rate, length and HT parameters. It then serialises the 24-bit L-SIG (and optionally the two 24-bit HT-SIG symbols with CRC-8) one bit per handshake toward the TX convolutional encoder. It sits between the TX control FSM and the encoder, running on the same clock as the receiver core.

## Interface
Parameters:
- HT_LEN_WIDTH, 16, width of the HT length field; fixed at 16 per HT-SIG1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- ht  in  1  1 = emit L-SIG + HT-SIG1 + HT-SIG2.
- legacy_rate  in  4  RATE field; legacy_rate[0] is R1 and is sent first.
- legacy_len  in  12  L-SIG LENGTH.
- ht_mcs  in  7  MCS.
- ht_cbw  in  1  CBW 20/40.
- ht_len  in  16  HT length.
- ht_smoothing  in  1  smoothing.
- ht_not_sounding  in  1  not-sounding.
- ht_aggr  in  1  aggregation.
- ht_stbc  in  2  STBC.
- ht_fec  in  1  FEC coding.
- ht_sgi  in  1  short GI.
- ht_num_ext  in  2  number of extension streams.
- bit_out  out  1  current header bit.
- bit_out_valid  out  1  bit_out is valid.
- bit_out_ready  in  1  consumer accepts bit_out this cycle.
- bit_out_last  out  1  high with bit 23 of each 24-bit symbol.
- sym_idx  out  2  symbol being sent: 0 = L-SIG, 1 = HT-SIG1, 2 = HT-SIG2.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final transfer.

## Operation
- FSM states are IDLE, LSIG, HTSIG1, HTSIG2.
- The 5-bit bit counter runs 0..23 within each state. A transfer happens when bit_out_valid & bit_out_ready.
- IDLE -> LSIG on start. All inputs are captured into internal registers that cycle; later input changes are ignored.
- LSIG bit layout:
  - bits 0-3: RATE. When ht=1, RATE is forced to 6 Mbps, i.e. sent bits 1,1,0,1.
  - bit 4: 0.
  - bits 5-16: LENGTH, LSB first.
  - bit 17: even parity over bits 0-16.
  - bits 18-23: 0.
- LSIG exit after bit 23: to HTSIG1 if latched ht=1, else to IDLE.
- HTSIG1 bit layout:
  - bits 0-6: MCS, LSB first.
  - bit 7: CBW.
  - bits 8-23: HT length, LSB first.
- HTSIG2 bit layout:
  - bit 0: smoothing.
  - bit 1: not_sounding.
  - bit 2: reserved, 1.
  - bit 3: aggr.
  - bits 4-5: STBC.
  - bit 6: FEC.
  - bit 7: SGI.
  - bits 8-9: num_ext.
  - bits 10-17: CRC, c7 first.
  - bits 18-23: 0.
- CRC:
  - Polynomial x^8+x^2+x+1, register initialised to 0xFF.
  - Computed serially over HT-SIG1 bits 0-23 and HT-SIG2 bits 0-9 as they are transferred.
  - The transmitted value is the ones-complement of the register.
- Parity and CRC update only on transfers.
- After the final bit the FSM returns to IDLE, busy=0 and done=1 for one cycle.
- start while busy=1 is ignored. start in the done cycle is accepted.

## Timing
- Reset values: bit_out=0, bit_out_valid=0, bit_out_last=0, sym_idx=0, busy=0, done=0, CRC=0xFF, counter=0.
- Start is accepted in cycle 0. busy and bit_out_valid go high in cycle 1, with bit 0 on bit_out.
- With bit_out_ready held at 1:
  - one bit per cycle;
  - legacy: last transfer in cycle 24, done in cycle 25;
  - HT: last transfer in cycle 72, done in cycle 73.
- Symbols follow each other with no gap.
- While bit_out_valid=1 and bit_out_ready=0: bit_out, bit_out_last and sym_idx hold, and valid stays high.
- bit_out_valid never drops mid-sequence.
- Reset asserted mid-sequence: all outputs return to reset values the next cycle and no done is produced. The next start begins from L-SIG bit 0.

## Configuration
- OPENOFDM_TX_HT_SIG_EN defined: HT-SIG generation and the CRC logic are compiled in, as above.
- OPENOFDM_TX_HT_SIG_EN undefined:
  - the HTSIG states and CRC are removed;
  - ht is treated as 0, so L-SIG only, using legacy_rate unforced;
  - ht_* ports remain but are unused;
  - sym_idx is always 0.

## Test plan
- Legacy, ready=1: legacy_rate=4'b1011, legacy_len=100, ht=0.
  - Sent bits 110100010011000000000000; parity bit 17 = 0.
  - bit_out_last in cycle 24, done in cycle 25.
- Backpressure: same stimulus, with bit_out_ready toggling every cycle.
  - Identical 24-bit sequence; each bit stable while valid & !ready.
  - done one cycle after the 24th transfer.
- HT with OPENOFDM_TX_HT_SIG_EN defined: ht=1 and all ht_* fields 0.
  - 72 bits; sym_idx sequence 0, 1, 2.
  - HT-SIG2 bits 0-9 = 0010000000, CRC bits 10-17 = 00111011 (0x3B).
  - done in cycle 73.
- ht=1 with the macro undefined: only 24 L-SIG bits using the unforced legacy_rate; sym_idx stays 0.
- start pulsed while busy at bit 5: no effect on the sequence and a single done.
- Reset mid-op: reset at L-SIG bit 10.
  - Next cycle valid=0, busy=0, no done.
  - A new start yields the full fresh sequence from bit 0.
